// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer holding long-latency results waiting for the write port.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;

    // Storage needs no reset; only pointers and occupancy are architectural.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and long-latency results onto the single register-file write port
// and tracks destinations of in-flight long-latency ops for the decode stall.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_valid,
    input  logic [REG_W-1:0]            alu_rd,
    input  logic [XLEN-1:0]             alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [REG_W-1:0]            ld_rd,
    input  logic [XLEN-1:0]             ld_data,
    input  logic                        ld_issue,
    input  logic [REG_W-1:0]            ld_issue_rd,
    input  logic [REG_W-1:0]            chk_rs1,
    input  logic [REG_W-1:0]            chk_rs2,
    input  logic [REG_W-1:0]            chk_rd,
    output logic                        stall,
    output logic                        wb_we,
    output logic [REG_W-1:0]            wb_rd,
    output logic [XLEN-1:0]             wb_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    wb_entry_t        head;
    wb_entry_t        ld_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             ld_live;
    logic             alu_win;
    logic             fifo_win;
    logic             byp_win;

    logic             wb_we_d;
    reg_idx_t         wb_rd_d;
    logic [XLEN-1:0]  wb_data_d;
    logic [NREG-1:0]  pending_q;
    logic [NREG-1:0]  pending_d;

    assign ld_entry = '{rd: ld_rd, data: ld_data};
    assign ld_ready = !fifo_full;

    // Accepted rd=0 results are swallowed here so they never reach FIFO or port.
    assign ld_live  = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign alu_win  = alu_valid && (alu_rd != REG_ZERO);
    assign fifo_win = !alu_win && !fifo_empty;
    assign byp_win  = !alu_win && fifo_empty && ld_live;
    assign push     = ld_live && (alu_win || !fifo_empty);
    assign pop      = fifo_win;

    wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (ld_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Winner selection and scoreboard update; a same-cycle set beats the clear.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd;
        wb_data_d = wb_data;
        pending_d = pending_q;
        if (alu_win) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
        end else if (fifo_win) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = head.rd;
            wb_data_d = head.data;
            pending_d[head.rd] = 1'b0;
        end else if (byp_win) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = ld_rd;
            wb_data_d = ld_data;
            pending_d[ld_rd] = 1'b0;
        end
        if (ld_issue && (ld_issue_rd != REG_ZERO)) begin
            pending_d[ld_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            pending_q <= '0;
        end else begin
            wb_we     <= wb_we_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            pending_q <= pending_d;
        end
    end

    assign stall = ((chk_rs1 != REG_ZERO) && pending_q[chk_rs1]) ||
                   ((chk_rs2 != REG_ZERO) && pending_q[chk_rs2]) ||
                   ((chk_rd  != REG_ZERO) && pending_q[chk_rd]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scenario bench for writeback_arbiter with an in-order expected-write scoreboard.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [31:0]     alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [31:0]     ld_data;
    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic [4:0]      chk_rd;
    logic            stall;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_data;
    logic [2:0]      fifo_count;

    int        checks;
    int        passes;
    wb_entry_t exp_q [$];

    writeback_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .stall       (stall),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic wb_entry_t mk(input logic [4:0] rd, input logic [31:0] data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && wb_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got rd=%0d data=%0h, required no write", wb_rd, wb_data);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data)
                    $display("FAIL wb_order: got rd=%0d data=%0h, required rd=%0d data=%0h",
                             wb_rd, wb_data, e.rd, e.data);
                else
                    passes++;
            end
        end
    end

    // Issuing to a destination that decode is checking must never happen while it stalls.
    always @(posedge clk) begin
        if (rst_n && ld_issue && ld_issue_rd != 5'd0 && chk_rd == ld_issue_rd)
            assert (!stall) else $error("ld_issue to pending rd %0d", ld_issue_rd);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    task automatic test_reset;
        checks += 6;
        if (wb_we !== 1'b0) $display("FAIL rst_we: got %0b, required 0", wb_we); else passes++;
        if (wb_rd !== 5'd0) $display("FAIL rst_rd: got %0d, required 0", wb_rd); else passes++;
        if (wb_data !== 32'd0) $display("FAIL rst_data: got %0h, required 0", wb_data); else passes++;
        if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d, required 0", fifo_count); else passes++;
        if (ld_ready !== 1'b1) $display("FAIL rst_ready: got %0b, required 1", ld_ready); else passes++;
        if (stall !== 1'b0) $display("FAIL rst_stall: got %0b, required 0", stall); else passes++;
    endtask

    task automatic test_alu_single;
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
        exp_q.push_back(mk(5'd5, 32'h11));
        tick;
        idle_inputs();
        checks += 5;
        if (wb_we !== 1'b1) $display("FAIL alu_we: got %0b, required 1", wb_we); else passes++;
        if (wb_rd !== 5'd5) $display("FAIL alu_rd: got %0d, required 5", wb_rd); else passes++;
        if (wb_data !== 32'h11) $display("FAIL alu_data: got %0h, required 11", wb_data); else passes++;
        if (ld_ready !== 1'b1) $display("FAIL alu_ready: got %0b, required 1", ld_ready); else passes++;
        if (stall !== 1'b0) $display("FAIL alu_stall: got %0b, required 0", stall); else passes++;
        tick;
    endtask

    task automatic test_contention;
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
        ld_valid = 1; ld_rd = 7; ld_data = 32'hB;
        exp_q.push_back(mk(5'd3, 32'hA));
        exp_q.push_back(mk(5'd7, 32'hB));
        tick;
        idle_inputs();
        checks += 2;
        if (fifo_count !== 3'd1) $display("FAIL cont_count1: got %0d, required 1", fifo_count); else passes++;
        if (wb_rd !== 5'd3) $display("FAIL cont_rd1: got %0d, required 3", wb_rd); else passes++;
        tick;
        checks += 3;
        if (fifo_count !== 3'd0) $display("FAIL cont_count2: got %0d, required 0", fifo_count); else passes++;
        if (wb_we !== 1'b1) $display("FAIL cont_we2: got %0b, required 1", wb_we); else passes++;
        if (wb_rd !== 5'd7) $display("FAIL cont_rd2: got %0d, required 7", wb_rd); else passes++;
        tick;
        checks++;
        if (exp_q.size() != 0) $display("FAIL cont_drain: got %0d left, required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_fifo_full;
        int acc;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1; alu_rd = 5'(10 + c); alu_data = 32'h100 + 32'(c);
            exp_q.push_back(mk(5'(10 + c), 32'h100 + 32'(c)));
            ld_valid = (acc < 5); ld_rd = 5'(24 + acc); ld_data = 32'h200 + 32'(acc);
            checks++;
            if (ld_ready !== (c < 4)) $display("FAIL full_ready%0d: got %0b, required %0b", c, ld_ready, c < 4);
            else passes++;
            if (ld_valid && ld_ready) acc++;
            tick;
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(5'(24 + k), 32'h200 + 32'(k)));
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        for (int c = 0; c < 5; c++) begin
            ld_valid = (acc < 5); ld_rd = 5'(24 + acc); ld_data = 32'h200 + 32'(acc);
            if (c < 2) begin
                checks++;
                if (ld_ready !== (c == 1)) $display("FAIL drain_ready%0d: got %0b, required %0b", c, ld_ready, c == 1);
                else passes++;
            end
            if (ld_valid && ld_ready) acc++;
            tick;
            checks++;
            if (wb_we !== 1'b1) $display("FAIL drain_we%0d: got %0b, required 1", c, wb_we); else passes++;
        end
        idle_inputs();
        tick;
        checks += 3;
        if (acc != 5) $display("FAIL full_accepted: got %0d, required 5", acc); else passes++;
        if (exp_q.size() != 0) $display("FAIL full_drain: got %0d left, required 0", exp_q.size()); else passes++;
        if (fifo_count !== 3'd0) $display("FAIL full_count: got %0d, required 0", fifo_count); else passes++;
    endtask

    task automatic test_scoreboard;
        ld_issue = 1; ld_issue_rd = 9; chk_rd = 9;
        checks++;
        if (stall !== 1'b0) $display("FAIL sb_pre: got %0b, required 0", stall); else passes++;
        tick;
        ld_issue = 0; ld_issue_rd = 0; chk_rd = 0; chk_rs1 = 9; chk_rs2 = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (stall !== 1'b1) $display("FAIL sb_hold%0d: got %0b, required 1", c, stall); else passes++;
            tick;
        end
        chk_rs1 = 1; chk_rs2 = 0; #1;
        checks++;
        if (stall !== 1'b0) $display("FAIL sb_rs2zero: got %0b, required 0", stall); else passes++;
        chk_rs1 = 0; chk_rs2 = 9; #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL sb_rs2: got %0b, required 1", stall); else passes++;
        chk_rs2 = 0; chk_rs1 = 9;
        ld_valid = 1; ld_rd = 9; ld_data = 32'h55;
        exp_q.push_back(mk(5'd9, 32'h55));
        #1;
        checks++;
        if (stall !== 1'b1) $display("FAIL sb_lastcyc: got %0b, required 1", stall); else passes++;
        tick;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        checks += 3;
        if (wb_we !== 1'b1 || wb_rd !== 5'd9) $display("FAIL sb_wb: got we=%0b rd=%0d, required we=1 rd=9", wb_we, wb_rd);
        else passes++;
        if (wb_data !== 32'h55) $display("FAIL sb_data: got %0h, required 55", wb_data); else passes++;
        if (stall !== 1'b0) $display("FAIL sb_release: got %0b, required 0", stall); else passes++;
        idle_inputs();
        tick;
    endtask

    task automatic test_x0;
        alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
        ld_valid = 1; ld_rd = 0; ld_data = 32'hBEEF;
        for (int c = 0; c < 2; c++) begin
            tick;
            checks += 3;
            if (wb_we !== 1'b0) $display("FAIL x0_we%0d: got %0b, required 0", c, wb_we); else passes++;
            if (fifo_count !== 3'd0) $display("FAIL x0_count%0d: got %0d, required 0", c, fifo_count); else passes++;
            if (ld_ready !== 1'b1) $display("FAIL x0_ready%0d: got %0b, required 1", c, ld_ready); else passes++;
        end
        idle_inputs();
        tick;
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 3; c++) begin
            ld_issue = 1; ld_issue_rd = 5'(21 + c); chk_rd = 5'(21 + c);
            tick;
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1; alu_rd = 5'(1 + c); alu_data = 32'h300 + 32'(c);
            exp_q.push_back(mk(5'(1 + c), 32'h300 + 32'(c)));
            ld_valid = 1; ld_rd = 5'(21 + c); ld_data = 32'h400 + 32'(c);
            tick;
        end
        idle_inputs();
        chk_rs1 = 21; #1;
        checks += 2;
        if (fifo_count !== 3'd3) $display("FAIL mid_count: got %0d, required 3", fifo_count); else passes++;
        if (stall !== 1'b1) $display("FAIL mid_stall: got %0b, required 1", stall); else passes++;
        rst_n = 0;
        exp_q.delete();
        #1;
        checks += 4;
        if (wb_we !== 1'b0) $display("FAIL mid_rst_we: got %0b, required 0", wb_we); else passes++;
        if (fifo_count !== 3'd0) $display("FAIL mid_rst_count: got %0d, required 0", fifo_count); else passes++;
        if (stall !== 1'b0) $display("FAIL mid_rst_stall: got %0b, required 0", stall); else passes++;
        if (ld_ready !== 1'b1) $display("FAIL mid_rst_ready: got %0b, required 1", ld_ready); else passes++;
        tick;
        rst_n = 1;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        ld_valid = 1; ld_rd = 6; ld_data = 32'h66;
        exp_q.push_back(mk(5'd4, 32'h44));
        exp_q.push_back(mk(5'd6, 32'h66));
        tick;
        idle_inputs();
        chk_rs1 = 21;
        tick; tick; tick;
        checks += 3;
        if (exp_q.size() != 0) $display("FAIL post_drain: got %0d left, required 0", exp_q.size()); else passes++;
        if (fifo_count !== 3'd0) $display("FAIL post_count: got %0d, required 0", fifo_count); else passes++;
        if (stall !== 1'b0) $display("FAIL post_stall: got %0b, required 0", stall); else passes++;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst_n = 0;
        idle_inputs();
        tick;
        tick;
        test_reset();
        rst_n = 1;
        tick;
        test_alu_single();
        test_contention();
        test_fifo_full();
        test_scoreboard();
        test_x0();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Write-side front end for the integer RegisterFile. It merges single-cycle ALU results with results from the long-latency load/mul-div path onto the single write port (RegWrite/rd/WriteData). Contending long-latency results are buffered in a small FIFO. A pending-register scoreboard drives the decode stall for RAW and WAW hazards. It sits between the execute/memory units and the register file.

Parameters:
XLEN, 32, data width
NREG, 32, architectural registers (index width 5)
FIFO_DEPTH, 4, long-latency result buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid this cycle (no backpressure)
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
ld_valid  in  1  long-latency result valid
ld_ready  out  1  arbiter can accept long-latency result
ld_rd  in  5  long-latency destination
ld_data  in  XLEN  long-latency result
ld_issue  in  1  long-latency op issued this cycle; mark ld_issue_rd pending
ld_issue_rd  in  5  destination of issued op
chk_rs1, chk_rs2, chk_rd  in  5 each  decode-stage operand/destination indices
stall  out  1  decode must hold
wb_we  out  1  to RegisterFile RegWrite
wb_rd  out  5  to RegisterFile rd
wb_data  out  XLEN  to RegisterFile WriteData
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n low): wb_we=0, wb_rd=0, wb_data=0, FIFO empty, fifo_count=0, all pending bits 0, ld_ready=1, stall=0. Reset mid-operation discards buffered results and pending bits.
- wb_we/wb_rd/wb_data are registered. Latency is 1 cycle from the winning input to the write port.
- Per-cycle winner selection, in priority order:
  1. ALU, if alu_valid and alu_rd!=0.
  2. FIFO head, if FIFO is non-empty.
  3. Incoming long-latency result (direct bypass), if accepted this cycle and FIFO is empty.
  4. Otherwise wb_we=0 next cycle; wb_rd/wb_data hold their previous values.
- ld_ready = !FIFO full (registered occupancy, no same-cycle pop credit). Accept = ld_valid && ld_ready.
- Accepted long-latency result:
  - pushed to the FIFO when the ALU wins or the FIFO is non-empty (ordering preserved);
  - otherwise written directly.
  - Simultaneous push and pop of the head is allowed when not full; occupancy is unchanged.
- Writes to x0 are dropped. An ALU result with rd=0 does not claim the port. An accepted long-latency result with rd=0 is consumed and never enqueued or written.
- Scoreboard pending[NREG]:
  - ld_issue with ld_issue_rd!=0 sets the bit.
  - The bit clears at the edge where a long-latency result for that rd is registered onto wb_*.
  - Set and clear on the same index in the same cycle: set wins.
  - pending[0] is always 0.
- stall (combinational from the pending register) = (chk_rs1!=0 && pending[chk_rs1]) || (chk_rs2!=0 && pending[chk_rs2]) || (chk_rd!=0 && pending[chk_rd]).
  - stall deasserts in the same cycle wb_we presents the result. RegisterFile write-through delivers WriteData to readers that cycle.
- ld_issue to an already-pending rd is illegal (prevented by stall on chk_rd); the bench asserts it never happens.
- An ALU write to a pending rd is illegal for the same reason.
- ld_valid while !ld_ready: the source holds ld_rd/ld_data stable until accepted.

Decomposition:
- Package wb_pkg:
  - XLEN;
  - reg_idx_t (logic [4:0]);
  - wb_entry_t struct {reg_idx_t rd; logic [XLEN-1:0] data};
  - REG_ZERO constant.
- Sub-module wb_fifo:
  - parameterised on depth and entry type;
  - wrap-around read/write pointers plus count;
  - push/pop/full/empty/count.
- The arbiter, scoreboard and output register live in writeback_arbiter.

Test Plan:
1. Reset, then alu_valid rd=5 data=0x11 -> next cycle wb_we=1, wb_rd=5, wb_data=0x11; ld_ready=1, stall=0.
2. Same cycle: alu rd=3 data=0xA and ld rd=7 data=0xB accepted -> cycle+1 writes x3=0xA, cycle+2 writes x7=0xB; fifo_count 1 then 0.
3. ALU valid every cycle, 5 ld results offered (FIFO_DEPTH=4) -> 4 accepted, ld_ready=0 on 5th; after the ALU stops, drain in order with 1 write/cycle; the 5th is accepted when space frees.
4. ld_issue rd=9, then chk_rs1=9 -> stall=1 until ld result rd=9 data=0x55 reaches wb; stall=0 in the wb_we cycle. chk_rs2=0 never stalls.
5. alu rd=0 and ld rd=0 offered -> no wb_we, FIFO stays empty, ld_ready stays 1.
6. Fill FIFO to 3 with pending bits set, assert rst_n low mid-stream -> immediately wb_we=0, fifo_count=0, stall=0; post-reset traffic writes only new results.
